secuenciador_notas: RTL and testbench

//  Tempo-driven step sequencer that sits directly upstream of the melody-level mux.

---
 rtl/secuenciador_notas.sv | 123 ++++++++++++
 tb/tb_secuenciador_notas.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/secuenciador_notas.sv
// Tempo-driven step sequencer: walks sel through 0..LAST_STEP at a fixed tempo and
// produces a note gate with a trailing articulation gap in every step.
module secuenciador_notas #(
  parameter int unsigned TICKS_PER_STEP = 6250000,
  parameter int unsigned GAP_TICKS      = 625000,
  parameter int unsigned LAST_STEP      = 25
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       stop,
  input  logic       pause,
  input  logic       loop_en,
  output logic [7:0] sel,
  output logic       gate,
  output logic       step_tick,
  output logic       busy,
  output logic       done,
  output logic [1:0] dbg_state
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PLAY   = 2'd1,
    PAUSED = 2'd2,
    FINISH = 2'd3
  } state_t;

  localparam logic [23:0] TICK_LAST = 24'(TICKS_PER_STEP - 1);
  localparam logic [23:0] GATE_END  = 24'(TICKS_PER_STEP - GAP_TICKS);
  localparam logic [7:0]  SEL_LAST  = 8'(LAST_STEP);

  state_t      state;
  logic [23:0] tick_cnt;

  assign dbg_state = state;

  // Outputs are all registered alongside the state; gate is computed from the
  // next tick_cnt so it lines up with the step that sel is presenting.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      tick_cnt  <= '0;
      sel       <= '0;
      gate      <= 1'b0;
      step_tick <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      step_tick <= 1'b0;
      done      <= 1'b0;
      if (stop) begin
        state    <= IDLE;
        tick_cnt <= '0;
        sel      <= '0;
        gate     <= 1'b0;
        busy     <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            tick_cnt <= '0;
            sel      <= '0;
            if (start) begin
              state     <= PLAY;
              step_tick <= 1'b1;
              busy      <= 1'b1;
              gate      <= (GATE_END != 24'd0);
            end else begin
              gate <= 1'b0;
              busy <= 1'b0;
            end
          end
          PLAY, PAUSED: begin
            busy <= 1'b1;
            if (pause) begin
              // Timer and step frozen; leaving PAUSED resumes with the next count.
              state <= PAUSED;
              gate  <= 1'b0;
            end else if (tick_cnt < TICK_LAST) begin
              state    <= PLAY;
              tick_cnt <= tick_cnt + 24'd1;
              gate     <= ((tick_cnt + 24'd1) < GATE_END);
            end else if (sel < SEL_LAST) begin
              state     <= PLAY;
              sel       <= sel + 8'd1;
              tick_cnt  <= '0;
              step_tick <= 1'b1;
              gate      <= (GATE_END != 24'd0);
            end else if (loop_en) begin
              state     <= PLAY;
              sel       <= '0;
              tick_cnt  <= '0;
              step_tick <= 1'b1;
              gate      <= (GATE_END != 24'd0);
            end else begin
              state    <= FINISH;
              sel      <= '0;
              tick_cnt <= '0;
              gate     <= 1'b0;
              busy     <= 1'b0;
              done     <= 1'b1;
            end
          end
          FINISH: begin
            state    <= IDLE;
            sel      <= '0;
            tick_cnt <= '0;
            gate     <= 1'b0;
            busy     <= 1'b0;
          end
          default: begin
            state    <= IDLE;
            sel      <= '0;
            tick_cnt <= '0;
            gate     <= 1'b0;
            busy     <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_secuenciador_notas.sv
// Bench for secuenciador_notas with a small tempo: directed scenarios plus random
// control traffic, all checked against a song-position reference model.
module tb_secuenciador_notas;

  localparam int T = 4;
  localparam int G = 1;
  localparam int L = 3;
  localparam int SONG_TICKS = (L + 1) * T;
  localparam int W = 14;

  localparam int M_IDLE   = 0;
  localparam int M_PLAY   = 1;
  localparam int M_PAUSED = 2;
  localparam int M_FINISH = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       pause = 1'b0;
  logic       loop_en = 1'b0;
  logic [7:0] sel;
  logic       gate;
  logic       step_tick;
  logic       busy;
  logic       done;
  logic [1:0] dbg_state;

  int n_checks = 0;
  int n_fail = 0;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] obs;
  logic [W-1:0] exp_v;

  // Reference model: the song is one absolute position m_el in 0..SONG_TICKS-1
  int m_mode = M_IDLE;
  int m_el = 0;

  secuenciador_notas #(
    .TICKS_PER_STEP(T),
    .GAP_TICKS(G),
    .LAST_STEP(L)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .stop(stop),
    .pause(pause),
    .loop_en(loop_en),
    .sel(sel),
    .gate(gate),
    .step_tick(step_tick),
    .busy(busy),
    .done(done),
    .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic model_step(input logic r, input logic s, input logic st,
                            input logic p, input logic l);
    logic       e_tick;
    logic       e_done;
    logic       e_busy;
    logic       e_gate;
    logic [7:0] e_sel;
    e_tick = 1'b0;
    e_done = 1'b0;
    if (r) begin
      m_mode = M_IDLE;
      m_el = 0;
    end else if (s) begin
      m_mode = M_IDLE;
    end else if (m_mode == M_IDLE) begin
      if (st) begin
        m_mode = M_PLAY;
        m_el = 0;
        e_tick = 1'b1;
      end
    end else if (m_mode == M_FINISH) begin
      m_mode = M_IDLE;
    end else if (p) begin
      m_mode = M_PAUSED;
    end else begin
      m_mode = M_PLAY;
      if (m_el + 1 < SONG_TICKS) begin
        m_el = m_el + 1;
        e_tick = ((m_el % T) == 0);
      end else if (l) begin
        m_el = 0;
        e_tick = 1'b1;
      end else begin
        m_mode = M_FINISH;
        e_done = 1'b1;
      end
    end
    e_busy = (m_mode == M_PLAY) || (m_mode == M_PAUSED);
    e_sel  = e_busy ? 8'(m_el / T) : 8'd0;
    e_gate = (m_mode == M_PLAY) && ((m_el % T) < (T - G));
    exp_q.push_back({e_sel, e_gate, e_tick, e_busy, e_done, 2'(m_mode)});
  endtask

  // Apply one cycle of inputs, let the edge happen, then sample 1 time unit later.
  task automatic drive(input logic r, input logic s, input logic st,
                       input logic p, input logic l);
    rst = r;
    stop = s;
    start = st;
    pause = p;
    loop_en = l;
    @(posedge clk);
    model_step(r, s, st, p, l);
    #1;
    obs = {sel, gate, step_tick, busy, done, dbg_state};
    exp_v = exp_q.pop_front();
  endtask

  task automatic test_reset();
    for (int i = 0; i < 12; i++) begin
      drive(i < 2, 1'b0, 1'b0, 1'b0, 1'b0);
      n_checks++;
      if (obs !== exp_v || obs !== '0) begin
        n_fail++;
        $display("FAIL reset cyc=%0d got=%h exp=%h", i, obs, exp_v);
      end
    end
  endtask

  task automatic test_single_shot();
    int ticks;
    int dones;
    ticks = 0;
    dones = 0;
    for (int i = 0; i < 19; i++) begin
      drive(1'b0, 1'b0, i == 0, 1'b0, 1'b0);
      ticks += int'(step_tick);
      dones += int'(done);
      n_checks++;
      if (obs !== exp_v) begin
        n_fail++;
        $display("FAIL single_shot cyc=%0d got=%h exp=%h", i, obs, exp_v);
      end
      // Step 3's fourth cycle is i=15, so done lands at i=16
      if (i == 16) begin
        n_checks++;
        if (done !== 1'b1 || busy !== 1'b0) begin
          n_fail++;
          $display("FAIL single_shot_done got done=%b busy=%b exp done=1 busy=0", done, busy);
        end
      end
    end
    n_checks++;
    if (ticks != 4 || dones != 1) begin
      n_fail++;
      $display("FAIL single_shot_counts got ticks=%0d dones=%0d exp ticks=4 dones=1", ticks, dones);
    end
  endtask

  task automatic test_loop();
    int dones;
    int not_busy;
    dones = 0;
    not_busy = 0;
    for (int i = 0; i < 41; i++) begin
      drive(1'b0, 1'b0, i == 0, 1'b0, 1'b1);
      dones += int'(done);
      not_busy += int'(!busy);
      n_checks++;
      if (obs !== exp_v) begin
        n_fail++;
        $display("FAIL loop cyc=%0d got=%h exp=%h", i, obs, exp_v);
      end
      if (i == 16) begin
        n_checks++;
        if (sel !== 8'd0 || step_tick !== 1'b1) begin
          n_fail++;
          $display("FAIL loop_wrap got sel=%0d step_tick=%b exp sel=0 step_tick=1", sel, step_tick);
        end
      end
    end
    n_checks++;
    if (dones != 0 || not_busy != 0) begin
      n_fail++;
      $display("FAIL loop_counts got dones=%0d idle_cycles=%0d exp 0 and 0", dones, not_busy);
    end
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    n_checks++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL loop_stop got=%h exp=%h", obs, exp_v);
    end
  endtask

  task automatic test_pause();
    // i=0 start (sel0 tick0), i=5 reaches sel1 tick1, i=6..10 pause held
    for (int i = 0; i < 14; i++) begin
      drive(1'b0, 1'b0, i == 0, (i >= 6) && (i <= 10), 1'b0);
      n_checks++;
      if (obs !== exp_v) begin
        n_fail++;
        $display("FAIL pause cyc=%0d got=%h exp=%h", i, obs, exp_v);
      end
      if (i >= 6 && i <= 10) begin
        n_checks++;
        if (sel !== 8'd1 || gate !== 1'b0 || busy !== 1'b1) begin
          n_fail++;
          $display("FAIL pause_hold cyc=%0d got sel=%0d gate=%b busy=%b exp 1,0,1", i, sel, gate, busy);
        end
      end
      if (i == 11 || i == 12) begin
        n_checks++;
        if (sel !== 8'd1 || gate !== (i == 11)) begin
          n_fail++;
          $display("FAIL pause_resume cyc=%0d got sel=%0d gate=%b exp sel=1 gate=%b", i, sel, gate, i == 11);
        end
      end
      if (i == 13) begin
        n_checks++;
        if (sel !== 8'd2 || step_tick !== 1'b1) begin
          n_fail++;
          $display("FAIL pause_next got sel=%0d step_tick=%b exp sel=2 step_tick=1", sel, step_tick);
        end
      end
    end
  endtask

  task automatic test_stop_start();
    // Still playing sel=2 from test_pause: stop and start together
    drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    n_checks++;
    if (obs !== exp_v || sel !== 8'd0 || busy !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL stop_start got=%h exp=%h", obs, exp_v);
    end
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b0, i == 2, 1'b0, 1'b0);
      n_checks++;
      if (obs !== exp_v) begin
        n_fail++;
        $display("FAIL stop_restart cyc=%0d got=%h exp=%h", i, obs, exp_v);
      end
    end
    n_checks++;
    if (sel !== 8'd0 || step_tick !== 1'b1 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL restart got sel=%0d tick=%b busy=%b exp 0,1,1", sel, step_tick, busy);
    end
  endtask

  task automatic test_rst_paused();
    // From sel0 tick0: 8 edges to sel2 tick0, pause 2 edges, then rst
    for (int i = 0; i < 11; i++) begin
      drive(i == 10, 1'b0, 1'b0, i >= 8, 1'b0);
      n_checks++;
      if (obs !== exp_v) begin
        n_fail++;
        $display("FAIL rst_paused cyc=%0d got=%h exp=%h", i, obs, exp_v);
      end
    end
    n_checks++;
    if (obs !== '0) begin
      n_fail++;
      $display("FAIL rst_paused_zero got=%h exp=0", obs);
    end
  endtask

  task automatic test_random();
    logic r, s, st, p, l;
    for (int i = 0; i < 600; i++) begin
      r  = ($urandom_range(0, 99) == 0);
      s  = ($urandom_range(0, 39) == 0);
      st = ($urandom_range(0, 5) == 0);
      p  = ($urandom_range(0, 6) == 0);
      l  = ($urandom_range(0, 2) != 0);
      drive(r, s, st, p, l);
      n_checks++;
      if (obs !== exp_v) begin
        n_fail++;
        $display("FAIL random cyc=%0d got=%h exp=%h", i, obs, exp_v);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_shot();
    test_loop();
    test_pause();
    test_stop_start();
    test_rst_paused();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
    $finish;
  end

endmodule
